// File: rtl/fpu_arb_pkg.sv
// Shared definitions for the two-requester bfloat16 fpu arbiter.
// Holds the one-hot op encodings, the FSM state type and common bfloat16 constants.
// No ports; imported by fpu_arb and fpu_arb_fpu.
package fpu_arb_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_DIV = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [15:0] ZERO = 16'h0000;
    localparam logic [15:0] ONE  = 16'h3F80;

    // An op is legal only when exactly one encoding bit is set.
    function automatic logic op_legal(input logic [3:0] op);
        return $onehot(op);
    endfunction

endpackage

// File: rtl/fpu_arb_fpu.sv
// Combinational bfloat16 fpu: add/sub/mul/div with truncation, subnormals flushed to zero.
// Latency: 0 cycles (pure combinational); no backpressure, the caller holds inputs stable.
// Ports: in1_i/in2_i operands, op_i one-hot op, out_o result, div_zero_err_o, overflow_o flags.
module fpu_arb_fpu
    import fpu_arb_pkg::*;
(
    input  logic [15:0] in1_i,
    input  logic [15:0] in2_i,
    input  logic [3:0]  op_i,
    output logic [15:0] out_o,
    output logic        div_zero_err_o,
    output logic        overflow_o
);

    logic       sa, sb, za, zb;
    logic [7:0] ea, eb, ma, mb;

    assign sa = in1_i[15];
    assign sb = in2_i[15];
    assign ea = in1_i[14:7];
    assign eb = in2_i[14:7];
    assign za = (ea == 8'd0);
    assign zb = (eb == 8'd0);
    assign ma = za ? 8'd0 : {1'b1, in1_i[6:0]};
    assign mb = zb ? 8'd0 : {1'b1, in2_i[6:0]};

    // Add/sub path: mantissas carry 3 extra low bits so the aligned operand
    // keeps some precision; the hidden bit sits at bit 10 of the 12-bit sum.
    logic              swap, sb_eff, big_s, sml_s;
    logic [7:0]        big_e, sml_e, big_m, sml_m, diff;
    logic [10:0]       aligned;
    logic [11:0]       sum, norm;
    logic [3:0]        lead;
    logic              as_s, as_zero;
    logic signed [9:0] as_e;
    logic [6:0]        as_frac;

    always_comb begin
        sb_eff  = sb ^ (op_i == OP_SUB);
        swap    = in2_i[14:0] > in1_i[14:0];
        big_s   = swap ? sb_eff : sa;
        sml_s   = swap ? sa : sb_eff;
        big_e   = swap ? eb : ea;
        sml_e   = swap ? ea : eb;
        big_m   = swap ? mb : ma;
        sml_m   = swap ? ma : mb;
        diff    = big_e - sml_e;
        aligned = (diff > 8'd10) ? 11'd0 : ({sml_m, 3'b000} >> diff);
        if (big_s == sml_s) begin
            sum = {1'b0, big_m, 3'b000} + {1'b0, aligned};
        end else begin
            sum = {1'b0, big_m, 3'b000} - {1'b0, aligned};
        end
        lead = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (sum[i]) lead = 4'(i);
        end
        as_zero = (sum == 12'd0);
        as_s    = big_s;
        as_e    = $signed({2'b00, big_e}) + $signed({6'd0, lead}) - 10'sd10;
        norm    = (lead == 4'd11) ? (sum >> 1) : (sum << (4'd10 - lead));
        as_frac = 7'(norm >> 3);
    end

    logic              res_s, res_zero, dz;
    logic signed [9:0] e_res;
    logic [6:0]        frac;
    logic [15:0]       prod, quot;

    always_comb begin
        out_o          = ZERO;
        div_zero_err_o = 1'b0;
        overflow_o     = 1'b0;
        res_s          = 1'b0;
        res_zero       = 1'b1;
        dz             = 1'b0;
        e_res          = 10'sd0;
        frac           = 7'd0;
        prod           = 16'd0;
        quot           = 16'd0;
        case (op_i)
            OP_ADD, OP_SUB: begin
                res_s    = as_s;
                res_zero = as_zero;
                e_res    = as_e;
                frac     = as_frac;
            end
            OP_MUL: begin
                res_s    = sa ^ sb;
                res_zero = za | zb;
                prod     = 16'(ma) * 16'(mb);
                e_res    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
                if (prod[15]) begin
                    e_res = e_res + 10'sd1;
                    frac  = 7'(prod >> 8);
                end else begin
                    frac  = 7'(prod >> 7);
                end
            end
            OP_DIV: begin
                res_s = sa ^ sb;
                if (zb) begin
                    dz             = 1'b1;
                    div_zero_err_o = 1'b1;
                end else begin
                    res_zero = za;
                    quot     = {ma, 8'd0} / {8'd0, mb};
                    e_res    = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;
                    if (quot[8]) begin
                        frac  = 7'(quot >> 1);
                    end else begin
                        e_res = e_res - 10'sd1;
                        frac  = 7'(quot);
                    end
                end
            end
            default: ;
        endcase

        if (res_zero || e_res < 10'sd1) begin
            out_o = {res_s, 15'd0};
        end else if (e_res > 10'sd254) begin
            overflow_o = 1'b1;
            out_o      = {res_s, 8'hFF, 7'd0};
        end else begin
            out_o = {res_s, 8'(e_res), frac};
        end
        // Division by zero returns signed infinity and is not an overflow.
        if (dz) begin
            overflow_o = 1'b0;
            out_o      = {res_s, 8'hFF, 7'd0};
        end
    end

endmodule

// File: rtl/fpu_arb.sv
// Two-requester round-robin front end sharing one bfloat16 fpu; IDLE/EXEC/RESP FSM.
// Latency: handshake in cycle N -> rsp_valid_o in N+EXEC_CYCLES+1 (N+1 for a non-one-hot op).
// Backpressure: one op in flight; readys stay low outside IDLE, RESP holds until rsp_ready_i.
// Ports: clk/rst (sync, active high); req0_*/req1_* valid/ready/op/a/b; rsp_* valid/ready/id/data/flags; busy_o.
module fpu_arb
    import fpu_arb_pkg::*;
#(
    parameter int EXEC_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid_i,
    output logic        req0_ready_o,
    input  logic [3:0]  req0_op_i,
    input  logic [15:0] req0_a_i,
    input  logic [15:0] req0_b_i,
    input  logic        req1_valid_i,
    output logic        req1_ready_o,
    input  logic [3:0]  req1_op_i,
    input  logic [15:0] req1_a_i,
    input  logic [15:0] req1_b_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic        rsp_id_o,
    output logic [15:0] rsp_data_o,
    output logic        rsp_div_zero_o,
    output logic        rsp_overflow_o,
    output logic        rsp_illegal_o,
    output logic        busy_o
);

    localparam logic [1:0] LAST = 2'(EXEC_CYCLES - 1);

    state_t      state;
    logic        prio;
    logic [1:0]  cnt;
    logic        id_q;
    logic [3:0]  fpu_op;
    logic [15:0] fpu_a, fpu_b;

    logic        sel, hs;
    logic [3:0]  op_in;
    logic [15:0] a_in, b_in;

    logic [15:0] fpu_out;
    logic        fpu_dz, fpu_ovf;

    // prio only breaks ties; a lone valid requester always wins.
    always_comb begin
        sel          = (req0_valid_i && req1_valid_i) ? prio : req1_valid_i;
        hs           = (state == IDLE) && !rst && (req0_valid_i || req1_valid_i);
        req0_ready_o = hs && !sel;
        req1_ready_o = hs && sel;
        op_in        = sel ? req1_op_i : req0_op_i;
        a_in         = sel ? req1_a_i  : req0_a_i;
        b_in         = sel ? req1_b_i  : req0_b_i;
    end

    // Operand registers load only for legal ops so the fpu inputs never
    // toggle outside EXEC, including on an illegal request.
    fpu_arb_fpu u_fpu (
        .in1_i          (fpu_a),
        .in2_i          (fpu_b),
        .op_i           (fpu_op),
        .out_o          (fpu_out),
        .div_zero_err_o (fpu_dz),
        .overflow_o     (fpu_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            prio           <= 1'b0;
            cnt            <= 2'd0;
            id_q           <= 1'b0;
            fpu_op         <= 4'd0;
            fpu_a          <= ZERO;
            fpu_b          <= ZERO;
            rsp_valid_o    <= 1'b0;
            rsp_id_o       <= 1'b0;
            rsp_data_o     <= ZERO;
            rsp_div_zero_o <= 1'b0;
            rsp_overflow_o <= 1'b0;
            rsp_illegal_o  <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        id_q   <= sel;
                        prio   <= ~sel;
                        busy_o <= 1'b1;
                        if (op_legal(op_in)) begin
                            fpu_op <= op_in;
                            fpu_a  <= a_in;
                            fpu_b  <= b_in;
                            cnt    <= 2'd0;
                            state  <= EXEC;
                        end else begin
                            rsp_valid_o    <= 1'b1;
                            rsp_id_o       <= sel;
                            rsp_data_o     <= ZERO;
                            rsp_div_zero_o <= 1'b0;
                            rsp_overflow_o <= 1'b0;
                            rsp_illegal_o  <= 1'b1;
                            state          <= RESP;
                        end
                    end
                end
                EXEC: begin
                    if (cnt == LAST) begin
                        cnt            <= 2'd0;
                        rsp_valid_o    <= 1'b1;
                        rsp_id_o       <= id_q;
                        rsp_data_o     <= fpu_out;
                        rsp_div_zero_o <= fpu_dz;
                        rsp_overflow_o <= fpu_ovf;
                        rsp_illegal_o  <= 1'b0;
                        state          <= RESP;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_o <= 1'b0;
                        busy_o      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fpu_arb.md
FPU_ARB -- requirements
Module: fpu_arb

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, SHALL set the cycles the operands are held on the fpu before the result is sampled; legal range 1..4.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-004 req0_valid_i  input  1  requester 0 holds an operation.
REQ-005 req0_ready_o  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_op_i  input  4  one-hot op: 0001 add, 0010 sub, 0100 mul, 1000 div.
REQ-007 req0_a_i / req0_b_i  input  16 each  bfloat16 operands in1 / in2.
REQ-008 req1_valid_i, req1_ready_o, req1_op_i, req1_a_i, req1_b_i  SHALL match REQ-004..007 for requester 1.
REQ-009 rsp_valid_o  output  1  result available.
REQ-010 rsp_ready_i  input  1  consumer takes the result.
REQ-011 rsp_id_o  output  1  index of the requester that owns the result.
REQ-012 rsp_data_o  output  16  bfloat16 result.
REQ-013 rsp_div_zero_o / rsp_overflow_o  output  1 each  fpu flags registered with the result.
REQ-014 rsp_illegal_o  output  1  op was not one-hot.
REQ-015 busy_o  output  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-017 In IDLE, arbitration SHALL grant exactly one valid requester. If one is valid, it is granted. If both are valid, the requester selected by priority pointer prio is granted.
REQ-018 reqN_ready_o SHALL be combinational: high only when state is IDLE and N is granted; the other ready SHALL be low.
REQ-019 On a handshake, op, a, b and id SHALL be captured into registers, and prio SHALL become the non-granted index.
REQ-020 A legal op SHALL move IDLE to EXEC. A non-one-hot op SHALL move IDLE directly to RESP with data 16'h0000, illegal=1 and both flags 0.
REQ-021 In EXEC, the registered operands and op SHALL drive the fpu, and a cycle counter SHALL run 0..EXEC_CYCLES-1.
REQ-022 On the last EXEC cycle, out_o, div_zero_err_o and overflow_o SHALL be registered into the rsp_* outputs, and the FSM SHALL move to RESP.
REQ-023 In RESP, rsp_valid_o SHALL be 1 and all rsp_* outputs SHALL stay stable until rsp_ready_i=1. That handshake SHALL move to IDLE, and rsp_valid_o SHALL fall the next cycle.
REQ-024 Latency: a handshake in cycle N SHALL give rsp_valid_o=1 in cycle N+EXEC_CYCLES+1, or N+1 for an illegal op.
REQ-025 No new request SHALL be accepted outside IDLE; with rsp_ready_i held high, peak throughput SHALL be one op per EXEC_CYCLES+2 cycles.
REQ-026 Requester inputs SHALL be ignored except during the handshake cycle; a valid that drops before being granted SHALL NOT be serviced.
REQ-027 rsp_ready_i SHALL have no effect outside RESP.
REQ-028 The fpu operand registers SHALL hold their last value outside EXEC, so there is no extra toggling.

Reset
REQ-029 On rst=1, in any state, the block SHALL go to IDLE and set prio=0, counter=0, rsp_valid_o=0, rsp_id_o=0, rsp_data_o=16'h0000 and all flag outputs 0. busy_o SHALL be 0, and any in-flight operation SHALL be discarded with no response.
REQ-030 While rst=1, both ready outputs SHALL be 0.

Structure
REQ-031 The shared package SHALL hold: op encodings OP_ADD/OP_SUB/OP_MUL/OP_DIV, the FSM state type, and the bfloat16 constants ZERO=16'h0000 and ONE=16'h3F80.
REQ-032 The block SHALL instantiate exactly one existing fpu as its single sub-module; it SHALL contain no arithmetic of its own.

Verification
REQ-033 req0 mul 3F80*4000, EXEC_CYCLES=1, rsp_ready_i=1 -> req0_ready_o in cycle N; rsp_valid_o in N+2 with data 4000, id 0, flags 0.
REQ-034 Both requesters valid every cycle after reset, req0 add 3F80+4000, req1 sub 4040-3F80 -> grants alternate 0,1,0,1. Responses are 4040 with id 0 and 4000 with id 1. No requester waits more than one foreign op.
REQ-035 req1 div 4000/0000 -> rsp_div_zero_o=1 and id=1. req0 mul 7F00*7F00 -> rsp_overflow_o=1.
REQ-036 req0 op 4'b0011 -> rsp_valid_o in N+1, data 0000, rsp_illegal_o=1, and the fpu operand registers unchanged.
REQ-037 With rsp_ready_i held 0 for 5 cycles in RESP -> rsp_* stable, both ready outputs 0, busy_o=1. Asserting rst during EXEC -> next cycle IDLE, rsp_valid_o=0, prio=0, and the discarded op never responds.
